// File: rtl/seq_multi_op.sv
// Serial multi-function unit: captures operands on start, counts set odd-index bits of a
// one bit per cycle, then registers compare / byte-rotate / error / XNOR results with done.
module seq_multi_op #(
    parameter int A_W       = 16,
    parameter int B_W       = 32,
    parameter int CMP_W     = 8,
    parameter int ROT_BYTES = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               c_en,
    input  logic                               sel_en,
    input  logic                               gate_en,
    input  logic [A_W-1:0]                     a,
    input  logic [B_W-1:0]                     b,
    input  logic                               x,
    input  logic                               y,
    input  logic                               z,
    input  logic                               err_clr,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(A_W/2+1)-1:0]         sum_out,
    output logic [1:0]                         cmp_out,
    output logic [B_W-1:0]                     h_out,
    output logic                               err_out,
    output logic                               xor_out
);

    localparam int HALF  = A_W / 2;
    localparam int SUM_W = $clog2(HALF + 1);
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int MW    = (A_W > CMP_W) ? A_W : CMP_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [B_W-1:0] rot_left_bytes(input logic [B_W-1:0] v);
        return (v << (8 * ROT_BYTES)) | (v >> (B_W - 8 * ROT_BYTES));
    endfunction

    function automatic logic [1:0] cmp_unsigned(input logic [MW-1:0] lhs, input logic [MW-1:0] rhs);
        logic [1:0] r;
        if (lhs == rhs) begin
            r = 2'b00;
        end else if (lhs < rhs) begin
            r = 2'b01;
        end else begin
            r = 2'b10;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [A_W-1:0]     a_q, a_d;
    logic [B_W-1:0]     b_q, b_d;
    logic               x_q, x_d, y_q, y_d, z_q, z_d;
    logic               c_en_q, c_en_d, sel_en_q, sel_en_d, gate_en_q, gate_en_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [1:0]         cmp_q, cmp_d;
    logic [B_W-1:0]     h_q, h_d;
    logic               err_q, err_d;
    logic               xor_q, xor_d;

    logic               odd_bit_s;
    logic [SUM_W-1:0]   acc_next_s;
    logic               err_set_s;
    logic [MW-1:0]      a_ext_s, key_ext_s;

    // Datapath helpers: current odd bit, running sum, zero-extended compare operands
    always_comb begin
        odd_bit_s  = a_q[{idx_q, 1'b1}];
        acc_next_s = acc_q + SUM_W'(odd_bit_s);
        a_ext_s    = MW'(a_q);
        key_ext_s  = MW'(b_q[B_W-1 -: CMP_W]);
    end

    // Next-state, capture and result-register logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        c_en_d    = c_en_q;
        sel_en_d  = sel_en_q;
        gate_en_d = gate_en_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cmp_d     = cmp_q;
        h_d       = h_q;
        xor_d     = xor_q;
        err_set_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    x_d       = x;
                    y_d       = y;
                    z_d       = z;
                    c_en_d    = c_en;
                    sel_en_d  = sel_en;
                    gate_en_d = gate_en;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = ST_COUNT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_COUNT: begin
                acc_d = acc_next_s;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(HALF - 1)) begin
                    // Last bit: results land on the same edge that enters DONE
                    state_d = ST_DONE;
                    sum_d   = acc_next_s;
                    if (c_en_q && sel_en_q && gate_en_q) begin
                        err_set_s = 1'b1;
                    end else if (c_en_q) begin
                        cmp_d = cmp_unsigned(a_ext_s, key_ext_s);
                    end else begin
                        cmp_d = cmp_q;
                    end
                    if (sel_en_q) begin
                        h_d = rot_left_bytes(b_q);
                    end else begin
                        h_d = h_q;
                    end
                    if (gate_en_q) begin
                        xor_d = x_q ^ ~(y_q ^ z_q);
                    end else begin
                        xor_d = xor_q;
                    end
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            z_q       <= 1'b0;
            c_en_q    <= 1'b0;
            sel_en_q  <= 1'b0;
            gate_en_q <= 1'b0;
            acc_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cmp_q     <= 2'b00;
            h_q       <= '0;
            err_q     <= 1'b0;
            xor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            c_en_q    <= c_en_d;
            sel_en_q  <= sel_en_d;
            gate_en_q <= gate_en_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sum_q     <= sum_d;
            cmp_q     <= cmp_d;
            h_q       <= h_d;
            err_q     <= err_d;
            xor_q     <= xor_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign cmp_out = cmp_q;
    assign h_out   = h_q;
    assign err_out = err_q;
    assign xor_out = xor_q;

endmodule

// File: tb/tb_seq_multi_op.sv
// Scoreboard bench for seq_multi_op: expected results are queued when a request is issued
// and compared when done pulses.
module tb_seq_multi_op;

    localparam int A_W       = 16;
    localparam int B_W       = 32;
    localparam int CMP_W     = 8;
    localparam int ROT_BYTES = 2;
    localparam int HALF      = A_W / 2;
    localparam int SUM_W     = $clog2(HALF + 1);

    logic             clk = 1'b0;
    logic             rst_n, start, c_en, sel_en, gate_en, x, y, z, err_clr;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic             busy, done, err_out, xor_out;
    logic [SUM_W-1:0] sum_out;
    logic [1:0]       cmp_out;
    logic [B_W-1:0]   h_out;

    seq_multi_op #(.A_W(A_W), .B_W(B_W), .CMP_W(CMP_W), .ROT_BYTES(ROT_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .c_en(c_en), .sel_en(sel_en),
        .gate_en(gate_en), .a(a), .b(b), .x(x), .y(y), .z(z), .err_clr(err_clr),
        .busy(busy), .done(done), .sum_out(sum_out), .cmp_out(cmp_out),
        .h_out(h_out), .err_out(err_out), .xor_out(xor_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               start_cyc;
        logic [SUM_W-1:0] sum;
        logic [1:0]       cmp;
        logic [B_W-1:0]   h;
        logic             err;
        logic             xo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]     m_cmp = 2'b00;
    logic [B_W-1:0] m_h   = '0;
    logic           m_err = 1'b0;
    logic           m_xor = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [SUM_W-1:0] model_odd_pop(input logic [A_W-1:0] v);
        int cnt = 0;
        for (int k = 0; k < HALF; k++) cnt += int'(v[2*k+1]);
        return SUM_W'(cnt);
    endfunction

    function automatic logic [1:0] model_cmp(input logic [A_W-1:0] va, input logic [B_W-1:0] vb);
        longint unsigned ka = longint'(va);
        longint unsigned kb = longint'(vb >> (B_W - CMP_W));
        if (ka == kb) return 2'b00;
        if (ka < kb)  return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [B_W-1:0] model_rot(input logic [B_W-1:0] v);
        logic [B_W-1:0] r = '0;
        for (int i = 0; i < B_W/8; i++) r[((i + ROT_BYTES) % (B_W/8))*8 +: 8] = v[i*8 +: 8];
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("latency", 64'(cyc - mon_e.start_cyc), 64'(HALF));
                check_val("sum_out", 64'(sum_out), 64'(mon_e.sum));
                check_val("cmp_out", 64'(cmp_out), 64'(mon_e.cmp));
                check_val("h_out",   64'(h_out),   64'(mon_e.h));
                check_val("err_out", 64'(err_out), 64'(mon_e.err));
                check_val("xor_out", 64'(xor_out), 64'(mon_e.xo));
            end
        end
    end

    task automatic scramble_inputs();
        a       = A_W'($urandom());
        b       = B_W'({$urandom(), $urandom()});
        x       = 1'($urandom_range(0, 1));
        y       = 1'($urandom_range(0, 1));
        z       = 1'($urandom_range(0, 1));
        c_en    = 1'($urandom_range(0, 1));
        sel_en  = 1'($urandom_range(0, 1));
        gate_en = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_zero();
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_sum",  64'(sum_out), 64'd0);
        check_val("rst_cmp",  64'(cmp_out), 64'd0);
        check_val("rst_h",    64'(h_out), 64'd0);
        check_val("rst_err",  64'(err_out), 64'd0);
        check_val("rst_xor",  64'(xor_out), 64'd0);
    endtask

    task automatic do_req(input logic [A_W-1:0] in_a, input logic [B_W-1:0] in_b,
                          input logic ce, input logic se, input logic ge,
                          input logic ix, input logic iy, input logic iz,
                          input bit clr_at_done, input bit pulse_start);
        exp_t e;
        bit   seen = 1'b0;
        @(negedge clk);
        a = in_a; b = in_b; c_en = ce; sel_en = se; gate_en = ge;
        x = ix; y = iy; z = iz; start = 1'b1;
        @(posedge clk);
        #1;
        e.start_cyc = cyc;
        start = 1'b0;
        check_val("busy_after_start", 64'(busy), 64'd1);
        scramble_inputs();
        e.sum = model_odd_pop(in_a);
        if (ce && se && ge) m_err = 1'b1;
        else if (ce) m_cmp = model_cmp(in_a, in_b);
        if (se) m_h = model_rot(in_b);
        if (ge) m_xor = ix ^ ~(iy ^ iz);
        e.cmp = m_cmp; e.h = m_h; e.err = m_err; e.xo = m_xor;
        sb_q.push_back(e);
        if (pulse_start) begin
            @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (clr_at_done) begin
            while (cyc < e.start_cyc + HALF - 1) begin
                @(posedge clk);
                #1;
            end
            err_clr = 1'b1;
            @(posedge clk);
            #1 err_clr = 1'b0;
        end
        for (int i = 0; i < 4*HALF + 8 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            check_val("done_timeout", 64'd0, 64'd1);
            sb_q.delete();
        end else begin
            @(negedge clk);
            check_val("done_one_cycle", 64'(done), 64'd0);
            check_val("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    task automatic do_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        check_val("err_clr", 64'(err_out), 64'(m_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; err_clr = 1'b0;
        scramble_inputs();
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero();
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("idle_busy", 64'(busy), 64'd0);

        do_req(16'hAAAA, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("sum_aaaa", 64'(sum_out), 64'd8);
        check_val("cmp_gt", 64'(cmp_out), 64'd2);
        do_req(16'h0012, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("cmp_eq", 64'(cmp_out), 64'd0);
        do_req(16'h0005, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("cmp_lt", 64'(cmp_out), 64'd1);
        check_val("sum_zero", 64'(sum_out), 64'd0);

        do_req(16'h1234, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("h_rot", 64'(h_out), 64'h0000_0000_CCDD_AABB);
        do_req(16'h4321, 32'h0102_0304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("h_hold", 64'(h_out), 64'h0000_0000_CCDD_AABB);

        // All enables: error wins over compare; a stray start during COUNT must not queue
        do_req(16'h0001, 32'hFF00_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("err_set", 64'(err_out), 64'd1);
        check_val("cmp_held", 64'(cmp_out), 64'd1);
        check_val("h_ff", 64'(h_out), 64'h0000_0000_0000_FF00);
        repeat (12) @(negedge clk);
        do_err_clr();
        do_req(16'h00F0, 32'h0F00_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("err_set_wins", 64'(err_out), 64'd1);
        do_err_clr();

        for (int v = 0; v < 8; v++) begin
            do_req(A_W'($urandom()), B_W'($urandom()), 1'b0, 1'b0, 1'b1,
                   v[2], v[1], v[0], 1'b0, 1'b0);
        end

        // Reset in the fourth COUNT cycle aborts the request
        @(negedge clk);
        a = 16'hFFFF; b = 32'h0; c_en = 1'b1; sel_en = 1'b1; gate_en = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all_zero();
        m_cmp = 2'b00; m_h = '0; m_err = 1'b0; m_xor = 1'b0;
        repeat (12) @(negedge clk);
        do_req(16'h8002, 32'h8000_1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            do_req(A_W'($urandom()), B_W'($urandom()), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (m_err) do_err_clr();
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
